fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the fetch address loaded at reset.
REQ-002 Parameter PC_STEP, default 8, SHALL be the byte increment per fetched 64-bit instruction.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 stall_in  input  1  SHALL be downstream backpressure; 1 = do not deliver an instruction.
REQ-006 redirect_valid  input  1  SHALL be a branch/exception redirect strobe.
REQ-007 redirect_pc  input  [0:63]  SHALL be the redirect target address.
REQ-008 imem_req_valid  output  1  SHALL be the instruction-memory request valid.
REQ-009 imem_req_ready  input  1  SHALL be the instruction-memory request ready.
REQ-010 imem_req_addr  output  [0:63]  SHALL be the request address.
REQ-011 imem_resp_valid  input  1  SHALL be the response strobe, one cycle per accepted request, in order.
REQ-012 imem_resp_data  input  [0:63]  SHALL be the response instruction.
REQ-013 ninstruction  output  [0:63]  SHALL drive the fetch buffer instruction input.
REQ-014 halt  output  1  SHALL drive the fetch buffer halt input; 1 = buffer loads STALL_INSTRUCTION.
REQ-015 fetch_pc  output  [0:63]  SHALL be the current fetch PC register.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, HOLD, DROP; at most one request outstanding.
REQ-017 halt and ninstruction SHALL be registered; in every non-delivery cycle halt=1 and ninstruction=STALL_INSTRUCTION.
REQ-018 IDLE SHALL go to REQ after one cycle unconditionally.
REQ-019 In REQ, imem_req_valid=1 and imem_req_addr=fetch_pc, held stable until imem_req_ready=1; valid&ready moves to WAIT.
REQ-020 imem_req_valid SHALL be 0 in all states other than REQ.
REQ-021 In WAIT with imem_resp_valid=1 and stall_in=0, the next cycle SHALL present halt=0 and ninstruction=imem_resp_data, fetch_pc SHALL advance by PC_STEP, and the state SHALL move to REQ.
REQ-022 In WAIT with imem_resp_valid=1 and stall_in=1, data SHALL be captured in a hold register and the state SHALL move to HOLD, with halt remaining 1.
REQ-023 In HOLD, on the first cycle with stall_in=0, the next cycle SHALL present halt=0 and ninstruction=hold register, fetch_pc SHALL advance by PC_STEP, and the state SHALL move to REQ.
REQ-024 halt=0 SHALL last exactly one cycle per delivered instruction, and instructions SHALL be delivered in fetch order without loss or duplication.
REQ-025 fetch_pc arithmetic SHALL be modulo 2^64; 64'hFFFF_FFFF_FFFF_FFF8 + 8 wraps to 0.
REQ-026 redirect_valid SHALL have priority over all other events and SHALL load fetch_pc with redirect_pc, bits [61:63] forced to 0.
REQ-027 A redirect in IDLE, HOLD, or REQ with no handshake in that cycle SHALL discard any held data and go to REQ.
REQ-028 A redirect in REQ with a handshake in the same cycle, or in WAIT with no response, SHALL go to DROP.
REQ-029 A redirect in WAIT coincident with imem_resp_valid SHALL discard that response and go to REQ.
REQ-030 In DROP, the next response SHALL be discarded, then the state SHALL go to REQ; a redirect in DROP SHALL update fetch_pc and stay in DROP.
REQ-031 The cycle after any redirect SHALL have halt=1; no delivery occurs in it.
REQ-032 imem_resp_valid in IDLE, REQ, or HOLD SHALL be ignored and flagged by a simulation assertion.

Reset
REQ-033 While rst=0: state=IDLE, fetch_pc=RESET_PC, imem_req_valid=0, halt=1, ninstruction=STALL_INSTRUCTION, hold register=0.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; instruction memory shares rst and drops it too.

Verification
REQ-035 Reset release, RESET_PC=0x100, ready=1, response 1 cycle after accept, stall_in=0 -> requests at 0x100, 0x108, 0x110; each response delivered with halt=0 for one cycle.
REQ-036 imem_req_ready low 3 cycles -> imem_req_addr stable, imem_req_valid held at 1, exactly one handshake.
REQ-037 Response 0xDEAD while stall_in=1 for 4 cycles -> halt=1 throughout, then one cycle of halt=0 with ninstruction=0xDEAD, next request at PC+8.
REQ-038 Redirect to 0x2005 while in WAIT -> DROP, next response discarded (halt stays 1), next request at 0x2000.
REQ-039 Redirect coincident with response -> response never delivered, next request at redirect target; PC 0xFFFF_FFFF_FFFF_FFF8 fetch -> next request at 0x0.
REQ-040 rst=0 asserted during HOLD -> next cycle all outputs at reset values; held instruction never delivered.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: keeps one instruction-memory request in flight and feeds the fetch buffer.
// Redirects take priority over every other event, and stale responses are dropped so they are never delivered.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC          = 64'h0,
    parameter logic [63:0] PC_STEP           = 64'd8,
    parameter logic [63:0] STALL_INSTRUCTION = 64'h0000_0000_0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [0:63] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [0:63] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [0:63] imem_resp_data,
    output logic [0:63] ninstruction,
    output logic        halt,
    output logic [0:63] fetch_pc
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] hold_q, hold_d;
    logic [63:0] ninstr_q, ninstr_d;
    logic        halt_q, halt_d;
    logic [63:0] redirect_target;

    // Instructions are 8-byte aligned, so the low three address bits are cleared.
    assign redirect_target = redirect_pc & ~64'h7;

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign fetch_pc       = pc_q;
    assign halt           = halt_q;
    assign ninstruction   = ninstr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            hold_q   <= '0;
            halt_q   <= 1'b1;
            ninstr_q <= STALL_INSTRUCTION;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hold_q   <= hold_d;
            halt_q   <= halt_d;
            ninstr_q <= ninstr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_d   = hold_q;
        halt_d   = 1'b1;
        ninstr_d = STALL_INSTRUCTION;
        if (redirect_valid) begin
            pc_d = redirect_target;
            // A response coinciding with a redirect in DROP retires the stale request, so waiting further would deadlock.
            case (state_q)
                REQ:     state_d = imem_req_ready ? DROP : REQ;
                WAIT:    state_d = imem_resp_valid ? REQ : DROP;
                DROP:    state_d = imem_resp_valid ? REQ : DROP;
                default: begin
                    state_d = REQ;
                    hold_d  = '0;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_req_ready) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (stall_in) begin
                            hold_d  = imem_resp_data;
                            state_d = HOLD;
                        end else begin
                            halt_d   = 1'b0;
                            ninstr_d = imem_resp_data;
                            pc_d     = pc_q + PC_STEP;
                            state_d  = REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        halt_d   = 1'b0;
                        ninstr_d = hold_q;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = REQ;
                    end
                end
                DROP: begin
                    if (imem_resp_valid) state_d = REQ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A response is legal only while a request is outstanding (WAIT) or being discarded (DROP).
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(imem_resp_valid && (state_q inside {IDLE, REQ, HOLD})));
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomised bench for fetch_ctrl, checked every cycle against a transaction-level model.
// The model tracks only outstanding/discard/held flags and the expected PC, never the controller's states.
module tb_fetch_ctrl;

    localparam logic [63:0] RESET_PC    = 64'h100;
    localparam logic [63:0] STEP        = 64'd8;
    localparam logic [63:0] STALL_INSTR = 64'h0000_0000_0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        redirect_valid;
    logic [0:63] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [0:63] imem_req_addr;
    logic        imem_resp_valid;
    logic [0:63] imem_resp_data;
    logic [0:63] ninstruction;
    logic        halt;
    logic [0:63] fetch_pc;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC(RESET_PC),
        .PC_STEP(STEP),
        .STALL_INSTRUCTION(STALL_INSTR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_in(stall_in),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .ninstruction(ninstruction),
        .halt(halt),
        .fetch_pc(fetch_pc)
    );

    int assertCount = 0;
    int failCount = 0;
    int obsDeliveries = 0;
    int handshakes = 0;
    logic [63:0] hsQ[$];

    // Reference model state
    logic [63:0] mPc, mReqAddr, mHeldData, expN;
    bit mOut, mDiscard, mHeld, mStart, expHalt;

    // Instruction memory: single outstanding request, fixed latency chosen at accept time
    bit envPend;
    int envCnt;
    int memLatency;
    logic [63:0] envData;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [63:0] memWord(input logic [63:0] addr);
        if (addr == 64'h300) return 64'hDEAD;
        return {addr[31:0] ^ 32'hC0DE_0000, addr[63:32] ^ 32'h1234_5678};
    endfunction

    // One clock cycle: check current outputs, drive inputs, advance memory and model, move to next negedge.
    task automatic applyStimulus(input bit rstV, input bit stallV, input bit redirV,
                                 input logic [63:0] redirPcV, input bit readyV);
        bit expValid, respV, dutValid, hs;
        logic [63:0] dutAddr;
        expValid = !mStart && !mOut && !mHeld;
        checkOutput("halt", 64'(halt), 64'(expHalt));
        checkOutput("ninstruction", ninstruction, expN);
        checkOutput("fetch_pc", fetch_pc, mPc);
        checkOutput("req_valid", 64'(imem_req_valid), 64'(expValid));
        if (expValid) checkOutput("req_addr", imem_req_addr, mPc);
        if (halt === 1'b0) obsDeliveries++;

        dutValid = imem_req_valid;
        dutAddr  = imem_req_addr;
        respV    = envPend && (envCnt == 0);

        rst             = rstV;
        stall_in        = stallV;
        redirect_valid  = redirV;
        redirect_pc     = redirPcV;
        imem_req_ready  = readyV;
        imem_resp_valid = respV;
        imem_resp_data  = respV ? envData : {$urandom, $urandom};

        if (!rstV) begin
            envPend = 1'b0;
        end else begin
            if (respV) envPend = 1'b0;
            else if (envPend) envCnt--;
            if (dutValid && readyV) begin
                envPend = 1'b1;
                envCnt  = memLatency - 1;
                envData = memWord(dutAddr);
                handshakes++;
                hsQ.push_back(dutAddr);
            end
        end

        expHalt = 1'b1;
        expN    = STALL_INSTR;
        if (!rstV) begin
            mPc = RESET_PC; mOut = 0; mDiscard = 0; mHeld = 0; mStart = 1;
        end else begin
            hs = expValid && readyV;
            if (redirV) begin
                if (mOut) begin
                    if (respV) begin mOut = 0; mDiscard = 0; end
                    else mDiscard = 1;
                end else if (hs) begin
                    mOut = 1; mDiscard = 1;
                end
                mHeld = 0; mStart = 0;
                mPc = redirPcV & ~64'h7;
            end else if (mStart) begin
                mStart = 0;
            end else if (hs) begin
                mOut = 1; mReqAddr = mPc;
            end else if (mOut && respV) begin
                mOut = 0;
                if (mDiscard) mDiscard = 0;
                else if (stallV) begin mHeld = 1; mHeldData = memWord(mReqAddr); end
                else begin expHalt = 0; expN = memWord(mReqAddr); mPc = mPc + STEP; end
            end else if (mHeld && !stallV) begin
                mHeld = 0; expHalt = 0; expN = mHeldData; mPc = mPc + STEP;
            end
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runCycles(input int n, input bit stallV, input bit readyV);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, stallV, 1'b0, '0, readyV);
    endtask

    task automatic redirectTo(input logic [63:0] pc, input bit stallV);
        applyStimulus(1'b1, stallV, 1'b1, pc, 1'b1);
    endtask

    // mode 0: in WAIT with no response this cycle; 1: response arriving this cycle; 2: holding data
    task automatic runUntil(input int mode, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (mode == 0 && mOut && !mDiscard && !(envPend && envCnt == 0)) return;
            if (mode == 1 && mOut && !mDiscard && envPend && envCnt == 0) return;
            if (mode == 2 && mHeld) return;
            applyStimulus(1'b1, mode == 2, 1'b0, '0, 1'b1);
        end
        assertCount++;
        failCount++;
        $display("[TB] FAIL wait_mode%0d: observed timeout after %0d cycles, expected condition reached", mode, budget);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no completion by %0t, expected end of test", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        mPc = RESET_PC; mReqAddr = '0; mHeldData = '0; expN = STALL_INSTR;
        mOut = 0; mDiscard = 0; mHeld = 0; mStart = 1; expHalt = 1;
        envPend = 0; envCnt = 0; envData = '0; memLatency = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("[TB] reset values");
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] sequential fetch from reset PC");
        obsDeliveries = 0; handshakes = 0; hsQ.delete();
        runCycles(12, 1'b0, 1'b1);
        checkOutput("start_deliveries", 64'(obsDeliveries), 64'd5);
        checkOutput("start_handshakes", 64'(handshakes), 64'd6);
        if (hsQ.size() >= 3) begin
            checkOutput("start_addr1", hsQ[1], 64'h108);
            checkOutput("start_addr2", hsQ[2], 64'h110);
        end

        $display("[TB] ready held low");
        handshakes = 0;
        runCycles(1, 1'b0, 1'b1);
        runCycles(3, 1'b0, 1'b0);
        runCycles(1, 1'b0, 1'b1);
        checkOutput("ready_low_handshakes", 64'(handshakes), 64'd1);

        $display("[TB] response under stall");
        obsDeliveries = 0;
        redirectTo(64'h300, 1'b1);
        runCycles(8, 1'b1, 1'b1);
        checkOutput("stall_no_delivery", 64'(obsDeliveries), 64'd0);
        runCycles(4, 1'b0, 1'b1);

        $display("[TB] redirect during WAIT");
        memLatency = 3;
        runUntil(0, 20);
        redirectTo(64'h2005, 1'b0);
        obsDeliveries = 0;
        runCycles(3, 1'b0, 1'b1);
        checkOutput("drop_no_delivery", 64'(obsDeliveries), 64'd0);
        runCycles(8, 1'b0, 1'b1);

        $display("[TB] redirect coincident with response, PC wrap");
        memLatency = 2;
        runUntil(1, 20);
        redirectTo(64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        hsQ.delete();
        runCycles(6, 1'b0, 1'b1);
        checkOutput("wrap_handshakes", 64'(hsQ.size()), 64'd2);
        if (hsQ.size() >= 2) begin
            checkOutput("wrap_addr0", hsQ[0], 64'hFFFF_FFFF_FFFF_FFF8);
            checkOutput("wrap_addr1", hsQ[1], 64'h0);
        end

        $display("[TB] reset during HOLD");
        memLatency = 1;
        runUntil(2, 20);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        obsDeliveries = 0;
        runCycles(3, 1'b0, 1'b1);
        checkOutput("reset_hold_no_delivery", 64'(obsDeliveries), 64'd0);
        runCycles(4, 1'b0, 1'b1);

        $display("[TB] random traffic");
        obsDeliveries = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] target;
            memLatency = $urandom_range(1, 4);
            target = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, $urandom} : {$urandom, $urandom};
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 19) == 0, target, $urandom_range(0, 3) != 0);
        end
        checkOutput("random_progress", 64'(obsDeliveries > 100), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
